keypad_controller: RTL and testbench
====================================

// Module: keypad_controller
// PURPOSE
//  Sequences the 4x4 keypad matrix: drives one-hot column strobes, samples synchronized rows,
//  debounces press and release, and emits one registered key code per physical keypress.
//  Sits between the keypad pins and the display/decode logic; replaces free-running column scanning.
// PARAMETERS
//  SCAN_DIV   5  clk cycles per scan tick (legal >= 4 so synced rows settle after a column change)
//  DB_TICKS   4  consecutive stable ticks required to accept a press or a release (legal >= 1)
// PORTS
//  clk        in   1  system clock
//  reset      in   1  synchronous, active-low reset
//  rows       in   4  raw keypad rows, active-high, asynchronous to clk
//  cols       out  4  one-hot column drive, bit0 = column 0
//  key_code   out  4  last accepted key = 4*row_idx + col_idx; holds until next accept
//  key_valid  out  1  single-cycle pulse when key_code updates
//  key_held   out  1  high while the accepted key is considered down
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=SCAN, cols=4'b0001, key_code=0, key_valid=0, key_held=0,
//   tick counter, debounce counter and both synchronizer stages = 0. Applies mid-operation; no pulse.
//  rows pass through a 2-flop synchronizer -> rows_s; all decisions use rows_s, sampled only on tick.
//  tick: counter 0..SCAN_DIV-1, tick=1 for one cycle when count==SCAN_DIV-1, then wraps to 0.
//  States (kp_state_t):
//   SCAN:  on tick, if rows_s is exactly one-hot -> latch col_idx, row_idx, rows_s; db_cnt=1;
//          go DB_PRESS, cols frozen. Else (zero or multi-bit) rotate cols 0001->0010->0100->1000->0001.
//   DB_PRESS: on tick, rows_s==latched -> db_cnt++; rows_s!=latched -> SCAN, cols advance one column.
//          When the increment makes db_cnt==DB_TICKS (immediately on the latching tick if DB_TICKS==1):
//          key_code<=4*row_idx+col_idx, key_valid=1 next cycle only, go HELD.
//   HELD:  cols frozen; on tick, rows_s latched bit == 0 -> db_cnt=1, go DB_REL; else stay.
//          Extra rows in the frozen column and keys in other columns are ignored.
//   DB_REL: on tick, latched bit==0 -> db_cnt++; latched bit==1 -> HELD. db_cnt==DB_TICKS -> SCAN,
//          cols advance one column, key_held falls on the same edge.
//  key_held = 1 in HELD and DB_REL; 0 in SCAN and DB_PRESS. key_held rises with key_valid.
//  Latency: rows edge -> key_valid = 2 sync cycles + up to SCAN_DIV*(4+DB_TICKS) cycles.
//  key_valid never asserts twice for one press; never asserts outside DB_PRESS->HELD transition.
//  db_cnt width $clog2(DB_TICKS+1); saturates never needed since state exits at DB_TICKS.
//  Outputs are all registered; no combinational path rows->outputs.
// STRUCTURE
//  keypad_pkg: kp_state_t enum {SCAN, DB_PRESS, HELD, DB_REL}; COL0..COL3 one-hot constants;
//   function onehot_idx(logic [3:0]) -> logic [1:0]; function is_onehot4(logic [3:0]) -> logic.
//  Sub-module scan_tick #(SCAN_DIV) (clk, reset, tick): tick generator, same reset rules.
//  Synchronizer, FSM, column rotator, latch and output registers live in keypad_controller.
// TESTING (SCAN_DIV=5, DB_TICKS=4)
//  1 reset low 3 cycles mid-scan -> cols=0001, key_code=0, key_valid=0, key_held=0 next edge.
//  2 rows=0010 only while cols=0100, held stable -> one key_valid pulse, key_code=6, key_held=1,
//    cols stays 0100 until release.
//  3 rows=0010 for 2 ticks then 0000 (bounce) -> no key_valid, scanning resumes at cols=1000.
//  4 after test 2, rows=0000 for 4 ticks -> key_held=0, cols=1000; re-press same key -> 2nd pulse, code 6.
//  5 rows=0101 in any column -> no debounce entry, no key_valid, cols keep rotating every 5 cycles.
//  6 reset low while HELD -> next edge outputs at reset values, no key_valid; release of rows later
//    produces no pulse.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: FSM states, column
// strobe constants and one-hot decode utilities.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DB_PRESS = 2'd1,
    HELD     = 2'd2,
    DB_REL   = 2'd3
  } kp_state_t;

  localparam logic [3:0] COL0 = 4'b0001;
  localparam logic [3:0] COL1 = 4'b0010;
  localparam logic [3:0] COL2 = 4'b0100;
  localparam logic [3:0] COL3 = 4'b1000;

  // Only meaningful for one-hot inputs; anything else decodes to 0.
  function automatic logic [1:0] onehot_idx(logic [3:0] v);
    logic [1:0] idx;
    case (v)
      COL1:    idx = 2'd1;
      COL2:    idx = 2'd2;
      COL3:    idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic is_onehot4(logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/keypad_if.sv
// Keypad pin and key-event bundle between the scanner and its host.
interface keypad_if;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (input rows, output cols, output key_code, output key_valid, output key_held);
  modport slave  (output rows, input cols, input key_code, input key_valid, input key_held);
endinterface

// File: rtl/scan_tick.sv
// Free-running scan tick: one-cycle pulse every SCAN_DIV clocks.
module scan_tick #(
  parameter int SCAN_DIV = 5
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!reset)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/keypad_controller.sv
// 4x4 keypad scanner: one-hot column strobes, synchronized row sampling on
// scan ticks, press/release debounce and one registered key event per press.
module keypad_controller
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 5,
  parameter int DB_TICKS = 4
) (
  input  logic     clk,
  input  logic     reset,
  keypad_if.master kp
);
  localparam int DBW = $clog2(DB_TICKS + 1);
  localparam logic [DBW-1:0] DB_DONE = DBW'(DB_TICKS);

  logic            tick;
  logic [3:0]      rows_meta, rows_s;
  kp_state_t       state, state_n;
  logic [3:0]      cols_q, cols_n;
  logic [DBW-1:0]  db_cnt, db_n, db_inc;
  logic [3:0]      lat_rows, lat_n;
  logic [1:0]      row_idx, row_n, col_idx, col_n;
  logic [3:0]      code_q, code_n;
  logic            valid_q, valid_n, held_q, held_n;

  scan_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  // Stage boundary: two-flop synchronizer for the asynchronous rows
  always_ff @(posedge clk) begin
    if (!reset) begin
      rows_meta <= '0;
      rows_s    <= '0;
    end else begin
      rows_meta <= kp.rows;
      rows_s    <= rows_meta;
    end
  end

  assign db_inc = db_cnt + 1'b1;

  always_comb begin
    state_n = state;
    cols_n  = cols_q;
    db_n    = db_cnt;
    lat_n   = lat_rows;
    row_n   = row_idx;
    col_n   = col_idx;
    code_n  = code_q;
    valid_n = 1'b0;
    if (tick) begin
      case (state)
        SCAN: begin
          if (is_onehot4(rows_s)) begin
            lat_n = rows_s;
            row_n = onehot_idx(rows_s);
            col_n = onehot_idx(cols_q);
            db_n  = DBW'(1);
            if (DB_DONE == DBW'(1)) begin
              code_n  = {onehot_idx(rows_s), onehot_idx(cols_q)};
              valid_n = 1'b1;
              state_n = HELD;
            end else begin
              state_n = DB_PRESS;
            end
          end else begin
            cols_n = {cols_q[2:0], cols_q[3]};
          end
        end
        DB_PRESS: begin
          if (rows_s != lat_rows) begin
            state_n = SCAN;
            cols_n  = {cols_q[2:0], cols_q[3]};
          end else if (db_inc == DB_DONE) begin
            db_n    = db_inc;
            code_n  = {row_idx, col_idx};
            valid_n = 1'b1;
            state_n = HELD;
          end else begin
            db_n = db_inc;
          end
        end
        HELD: begin
          // Only the latched row of the frozen column matters while held.
          if ((rows_s & lat_rows) == 4'd0) begin
            db_n = DBW'(1);
            if (DB_DONE == DBW'(1)) begin
              state_n = SCAN;
              cols_n  = {cols_q[2:0], cols_q[3]};
            end else begin
              state_n = DB_REL;
            end
          end
        end
        DB_REL: begin
          if ((rows_s & lat_rows) != 4'd0) begin
            state_n = HELD;
          end else if (db_inc == DB_DONE) begin
            db_n    = db_inc;
            state_n = SCAN;
            cols_n  = {cols_q[2:0], cols_q[3]};
          end else begin
            db_n = db_inc;
          end
        end
        default: state_n = SCAN;
      endcase
    end
    held_n = (state_n == HELD) || (state_n == DB_REL);
  end

  // Stage boundary: FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= SCAN;
      cols_q   <= COL0;
      db_cnt   <= '0;
      lat_rows <= '0;
      row_idx  <= '0;
      col_idx  <= '0;
      code_q   <= '0;
      valid_q  <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      state    <= state_n;
      cols_q   <= cols_n;
      db_cnt   <= db_n;
      lat_rows <= lat_n;
      row_idx  <= row_n;
      col_idx  <= col_n;
      code_q   <= code_n;
      valid_q  <= valid_n;
      held_q   <= held_n;
    end
  end

  assign kp.cols      = cols_q;
  assign kp.key_code  = code_q;
  assign kp.key_valid = valid_q;
  assign kp.key_held  = held_q;

endmodule

// File: tb/tb_keypad_controller.sv
// Directed bench for keypad_controller with SCAN_DIV=5, DB_TICKS=4.
module tb_keypad_controller;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  keypad_if ifc ();

  keypad_controller #(.SCAN_DIV(5), .DB_TICKS(4)) dut (
    .clk  (clk),
    .reset(reset),
    .kp   (ifc.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cols(input string tag, input logic [3:0] c, input int budget);
    int n = 0;
    while (ifc.cols !== c && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, ifc.cols, c);
  endtask

  task automatic wait_unheld(input string tag, input int budget);
    int n = 0;
    while (ifc.key_held !== 1'b0 && n < budget) begin
      @(negedge clk);
      if (ifc.key_valid === 1'b1) check({tag, "_no_pulse"}, 1, 0);
      n++;
    end
    check(tag, ifc.key_held, 1'b0);
  endtask

  // Press key 6 (row 1, column 2) and watch the debounce for ncyc cycles.
  task automatic press_key6(input string tag, input int ncyc);
    int pulses = 0;
    logic [3:0] code = 4'hf;
    wait_cols({tag, "_wait_col2"}, 4'b0100, 40);
    ifc.rows = 4'b0010;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (ifc.key_valid === 1'b1) begin
        pulses++;
        code = ifc.key_code;
        check({tag, "_held_with_valid"}, ifc.key_held, 1'b1);
      end
      if (ifc.cols !== 4'b0100) check({tag, "_cols_frozen"}, ifc.cols, 4'b0100);
    end
    check({tag, "_pulses"}, pulses, 1);
    check({tag, "_code"}, code, 4'd6);
    check({tag, "_held"}, ifc.key_held, 1'b1);
    check({tag, "_cols"}, ifc.cols, 4'b0100);
  endtask

  initial begin
    int pulses;
    logic [3:0] c;
    ifc.rows = 4'b0000;
    reset    = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // 1: reset mid-scan
    repeat (12) @(negedge clk);
    check("t1_cols_moved", ifc.cols, 4'b0100);
    reset = 1'b0;
    @(negedge clk);
    check("t1_cols", ifc.cols, 4'b0001);
    check("t1_code", ifc.key_code, 4'd0);
    check("t1_valid", ifc.key_valid, 1'b0);
    check("t1_held", ifc.key_held, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("t1_cols_hold", ifc.cols, 4'b0001);
    @(negedge clk);
    check("t1_first_rotate", ifc.cols, 4'b0010);

    // 2: press key 6
    press_key6("t2", 40);

    // 4: release, then re-press
    ifc.rows = 4'b0000;
    wait_unheld("t4_release", 60);
    check("t4_cols", ifc.cols, 4'b1000);
    press_key6("t4_repress", 40);

    // 3: bounce of two ticks gives no key
    ifc.rows = 4'b0000;
    wait_unheld("t3_pre_release", 60);
    wait_cols("t3_wait_col2", 4'b0100, 40);
    pulses = 0;
    ifc.rows = 4'b0010;
    repeat (10) begin
      @(negedge clk);
      if (ifc.key_valid === 1'b1) pulses++;
    end
    ifc.rows = 4'b0000;
    repeat (6) begin
      @(negedge clk);
      if (ifc.key_valid === 1'b1) pulses++;
    end
    check("t3_pulses", pulses, 0);
    check("t3_cols", ifc.cols, 4'b1000);
    check("t3_held", ifc.key_held, 1'b0);

    // 5: multi-bit rows never enter debounce
    ifc.rows = 4'b0101;
    repeat (3) @(negedge clk);
    c = ifc.cols;
    while (ifc.cols === c) @(negedge clk);
    c = ifc.cols;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      repeat (4) begin
        @(negedge clk);
        if (ifc.key_valid === 1'b1) pulses++;
        if (ifc.cols !== c) check("t5_cols_steady", ifc.cols, c);
      end
      @(negedge clk);
      c = {c[2:0], c[3]};
      check("t5_rotate", ifc.cols, c);
    end
    check("t5_pulses", pulses, 0);
    check("t5_held", ifc.key_held, 1'b0);

    // 6: reset while held, then release produces nothing
    ifc.rows = 4'b0000;
    repeat (3) @(negedge clk);
    press_key6("t6_press", 40);
    reset = 1'b0;
    @(negedge clk);
    check("t6_cols", ifc.cols, 4'b0001);
    check("t6_code", ifc.key_code, 4'd0);
    check("t6_valid", ifc.key_valid, 1'b0);
    check("t6_held", ifc.key_held, 1'b0);
    ifc.rows = 4'b0000;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    repeat (60) begin
      @(negedge clk);
      if (ifc.key_valid === 1'b1) pulses++;
    end
    check("t6_no_pulse", pulses, 0);
    check("t6_held_after", ifc.key_held, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
